// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory controller and the data memory itself:
// FSM state encoding, memory window constants and the address window check.
package mem_pkg;

    localparam int unsigned BASE_ADDR = 1024;
    localparam int unsigned DEPTH     = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_DONE
    } state_e;

    // Word-aligned and inside [base, base + 4*depth); 34-bit limit avoids wrap near 2^32.
    function automatic logic addr_in_window(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input logic [31:0] depth);
        logic [33:0] limit;
        limit = {2'b00, base} + {depth, 2'b00};
        return (addr >= base) && ({2'b00, addr} < limit) && (addr[1:0] == 2'b00);
    endfunction

    function automatic logic addr_ok(input logic [31:0] addr);
        return addr_in_window(addr, BASE_ADDR, DEPTH);
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Pipeline-side request/response bundle of the data-memory controller.
// The MEM stage drives the master side, the controller implements the slave side.
interface data_mem_ctrl_if;
    logic        req_read;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        freeze;

    modport master (
        output req_read, req_write, req_addr, req_wdata,
        input  rdata, ready, err, freeze
    );

    modport slave (
        input  req_read, req_write, req_addr, req_wdata,
        output rdata, ready, err, freeze
    );
endinterface

// File: rtl/data_mem.sv
// Data memory: DEPTH 32-bit words starting at byte address BASE,
// combinational read, write on the rising clock edge.
module data_mem #(
    parameter int unsigned BASE = mem_pkg::BASE_ADDR,
    parameter int unsigned DEP  = mem_pkg::DEPTH
) (
    input  logic        clk,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_data,
    output logic [31:0] mem_res
);
    localparam int AW = (DEP > 1) ? $clog2(DEP) : 1;

    logic [31:0]   mem_q [DEP];
    logic [31:0]   offset;
    logic [AW-1:0] idx;
    logic          unused_offset_bits;

    assign offset             = mem_address - BASE;
    assign idx                = offset[AW+1:2];
    assign unused_offset_bits = ^{offset[31:AW+2], offset[1:0]};

    always_ff @(posedge clk) begin
        if (mem_write) begin
            mem_q[idx] <= mem_data;
        end
    end

    assign mem_res = mem_read ? mem_q[idx] : '0;

endmodule

// File: rtl/data_mem_ctrl.sv
// Sequencer between the MEM stage and the data memory: latches one request,
// waits WAIT_CYCLES, strobes the memory for one cycle and stalls the pipeline meanwhile.
module data_mem_ctrl #(
    parameter int unsigned WAIT_CYCLES = 4,
    parameter int unsigned BASE_ADDR   = mem_pkg::BASE_ADDR,
    parameter int unsigned DEPTH       = mem_pkg::DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    data_mem_ctrl_if.slave        bus,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [31:0]           mem_address,
    output logic [31:0]           mem_data,
    input  logic [31:0]           mem_res
);
    import mem_pkg::*;

    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = (WAIT_CYCLES == 0) ? '0 : CW'(WAIT_CYCLES - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fault_q, fault_d;
    logic          wr_q, wr_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          req_any;
    logic          req_ok;

    assign req_any = bus.req_read || bus.req_write;
    assign req_ok  = addr_in_window(bus.req_addr, BASE_ADDR, DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    // A simultaneous read and write is treated as a write.
                    wr_d    = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    fault_d = !req_ok;
                    if (!req_ok) begin
                        state_d = ST_DONE;
                        rdata_d = '0;
                    end else if (WAIT_CYCLES == 0) begin
                        state_d = ST_ACCESS;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ACCESS: begin
                state_d = ST_DONE;
                if (!wr_q) begin
                    rdata_d = mem_res;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Freeze drops in DONE so the pipeline advances on the completing edge.
    assign bus.freeze = (state_q == ST_IDLE && req_any) ||
                        (state_q == ST_WAIT) || (state_q == ST_ACCESS);
    assign bus.ready  = (state_q == ST_DONE);
    assign bus.err    = (state_q == ST_DONE) && fault_q;
    assign bus.rdata  = rdata_q;

    assign mem_read    = (state_q == ST_ACCESS) && !wr_q;
    assign mem_write   = (state_q == ST_ACCESS) && wr_q;
    assign mem_address = (state_q == ST_WAIT || state_q == ST_ACCESS) ? addr_q  : '0;
    assign mem_data    = (state_q == ST_WAIT || state_q == ST_ACCESS) ? wdata_q : '0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Two controller+memory slices (WAIT_CYCLES 4 and 0) checked every cycle against a
// cycle-offset model, plus directed transactions with literal expectations.
module tb_data_mem_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_rd [2];
    logic        req_wr [2];
    logic [31:0] req_addr [2];
    logic [31:0] req_wdata [2];
    logic [31:0] rdata_w [2];
    logic        ready_w [2];
    logic        err_w [2];
    logic        freeze_w [2];
    logic        mrd_w [2];
    logic        mwr_w [2];
    logic [31:0] maddr_w [2];
    logic [31:0] mdata_w [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_slice
        data_mem_ctrl_if bus ();
        logic        mem_read;
        logic        mem_write;
        logic [31:0] mem_address;
        logic [31:0] mem_data;
        logic [31:0] mem_res;

        assign bus.req_read  = req_rd[gi];
        assign bus.req_write = req_wr[gi];
        assign bus.req_addr  = req_addr[gi];
        assign bus.req_wdata = req_wdata[gi];
        assign rdata_w[gi]   = bus.rdata;
        assign ready_w[gi]   = bus.ready;
        assign err_w[gi]     = bus.err;
        assign freeze_w[gi]  = bus.freeze;
        assign mrd_w[gi]     = mem_read;
        assign mwr_w[gi]     = mem_write;
        assign maddr_w[gi]   = mem_address;
        assign mdata_w[gi]   = mem_data;

        data_mem_ctrl #(.WAIT_CYCLES((gi == 0) ? 4 : 0)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .bus         (bus),
            .mem_read    (mem_read),
            .mem_write   (mem_write),
            .mem_address (mem_address),
            .mem_data    (mem_data),
            .mem_res     (mem_res)
        );

        data_mem u_mem (
            .clk         (clk),
            .mem_read    (mem_read),
            .mem_write   (mem_write),
            .mem_address (mem_address),
            .mem_data    (mem_data),
            .mem_res     (mem_res)
        );
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_busy [2];
    int          m_k [2];
    bit          m_wr [2];
    bit          m_fault [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wdata [2];
    logic [31:0] m_rdata [2];
    logic [31:0] shadow [2][64];

    function automatic int w_of(input int i);
        return (i == 0) ? 4 : 0;
    endfunction

    function automatic bit bad_addr(input logic [31:0] a);
        return (a < 32'd1024) || (a >= 32'd1280) || (a % 4 != 0);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a - 32'd1024) / 4);
    endfunction

    task automatic check_outputs(input int i);
        int          w;
        logic        e_frz, e_rdy, e_err, e_mr, e_mw;
        logic [31:0] e_ma, e_md;
        string       p;
        w = w_of(i);
        e_frz = 0; e_rdy = 0; e_err = 0; e_mr = 0; e_mw = 0; e_ma = '0; e_md = '0;
        if (!m_busy[i]) begin
            e_frz = req_rd[i] | req_wr[i];
        end else if (m_fault[i]) begin
            e_rdy = 1; e_err = 1;
        end else if (m_k[i] <= w + 1) begin
            e_frz = 1; e_ma = m_addr[i]; e_md = m_wdata[i];
            if (m_k[i] == w + 1) begin
                e_mw = m_wr[i]; e_mr = !m_wr[i];
            end
        end else begin
            e_rdy = 1;
        end
        p = $sformatf("w%0d.", w);
        cmp({p, "freeze"}, 32'(freeze_w[i]), 32'(e_frz));
        cmp({p, "ready"},  32'(ready_w[i]),  32'(e_rdy));
        cmp({p, "err"},    32'(err_w[i]),    32'(e_err));
        cmp({p, "mem_read"},  32'(mrd_w[i]), 32'(e_mr));
        cmp({p, "mem_write"}, 32'(mwr_w[i]), 32'(e_mw));
        cmp({p, "mem_address"}, maddr_w[i], e_ma);
        cmp({p, "mem_data"},    mdata_w[i], e_md);
        cmp({p, "rdata"},       rdata_w[i], m_rdata[i]);
    endtask

    task automatic step_model(input int i);
        int w;
        w = w_of(i);
        // A write in its access cycle lands in memory even if reset is asserted.
        if (m_busy[i] && !m_fault[i] && m_k[i] == w + 1 && m_wr[i])
            shadow[i][word_of(m_addr[i])] = m_wdata[i];
        if (rst) begin
            m_busy[i]  = 0;
            m_rdata[i] = '0;
        end else if (!m_busy[i]) begin
            if (req_rd[i] || req_wr[i]) begin
                m_busy[i]  = 1;
                m_k[i]     = 1;
                m_wr[i]    = req_wr[i];
                m_addr[i]  = req_addr[i];
                m_wdata[i] = req_wdata[i];
                m_fault[i] = bad_addr(req_addr[i]);
                if (m_fault[i]) m_rdata[i] = '0;
            end
        end else begin
            if (!m_fault[i] && m_k[i] == w + 1 && !m_wr[i])
                m_rdata[i] = shadow[i][word_of(m_addr[i])];
            if (m_fault[i] ? (m_k[i] == 1) : (m_k[i] == w + 2)) m_busy[i] = 0;
            else m_k[i]++;
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_k[i] = 0; m_rdata[i] = '0;
        end
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check_outputs(i);
                step_model(i);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic run_req(input int i, input bit rd, input bit wr,
                           input logic [31:0] a, input logic [31:0] d,
                           output int rdy_cyc, output int frz, output int nw, output int nr,
                           output logic e, output logic [31:0] rv);
        req_rd[i] = rd; req_wr[i] = wr; req_addr[i] = a; req_wdata[i] = d;
        rdy_cyc = -1; frz = 0; nw = 0; nr = 0; e = 1'bx; rv = 'x;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            frz += int'(freeze_w[i]);
            nw  += int'(mwr_w[i]);
            nr  += int'(mrd_w[i]);
            if (ready_w[i]) begin
                rdy_cyc = c; e = err_w[i]; rv = rdata_w[i];
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        req_rd[i] = 0; req_wr[i] = 0;
        $display("txn w%0d rd=%0b wr=%0b addr=%0d wdata=0x%08h -> ready@%0d freeze=%0d wr=%0d rd=%0d err=%0b rdata=0x%08h",
                 w_of(i), rd, wr, a, d, rdy_cyc, frz, nw, nr, e, rv);
    endtask

    initial begin
        int          rc, fz, nw, nr;
        logic        e;
        logic [31:0] rv;
        logic [31:0] faults [3];
        faults[0] = 32'd1020; faults[1] = 32'd1280; faults[2] = 32'd1026;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_rd[i] = 0; req_wr[i] = 0; req_addr[i] = '0; req_wdata[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cmp("reset.rdata",  rdata_w[0], 32'h0);
        cmp("reset.ready",  32'(ready_w[0]), 32'h0);
        cmp("reset.freeze", 32'(freeze_w[0]), 32'h0);
        cmp("reset.mem_write", 32'(mwr_w[0]), 32'h0);
        cmp("reset.mem_address", maddr_w[0], 32'h0);

        // Store then load with four wait cycles.
        run_req(0, 0, 1, 32'd1024, 32'hDEADBEEF, rc, fz, nw, nr, e, rv);
        cmp("st1024.ready_cycle", 32'(rc), 32'd6);
        cmp("st1024.freeze_cycles", 32'(fz), 32'd6);
        cmp("st1024.mem_write_pulses", 32'(nw), 32'd1);
        cmp("st1024.mem_read_pulses", 32'(nr), 32'd0);
        run_req(0, 1, 0, 32'd1024, 32'h0, rc, fz, nw, nr, e, rv);
        cmp("ld1024.freeze_cycles", 32'(fz), 32'd6);
        cmp("ld1024.ready_cycle", 32'(rc), 32'd6);
        cmp("ld1024.rdata", rv, 32'hDEADBEEF);
        cmp("ld1024.err", 32'(e), 32'h0);

        // Rejected addresses: below window, one past the end, misaligned.
        foreach (faults[f]) begin
            run_req(0, 1, 0, faults[f], 32'h0, rc, fz, nw, nr, e, rv);
            cmp($sformatf("fault%0d.ready_cycle", faults[f]), 32'(rc), 32'd1);
            cmp($sformatf("fault%0d.err", faults[f]), 32'(e), 32'h1);
            cmp($sformatf("fault%0d.rdata", faults[f]), rv, 32'h0);
            cmp($sformatf("fault%0d.strobes", faults[f]), 32'(nw + nr), 32'd0);
            cmp($sformatf("fault%0d.freeze_cycles", faults[f]), 32'(fz), 32'd1);
        end

        // Read+write together: write wins, rdata untouched.
        run_req(0, 1, 0, 32'd1024, 32'h0, rc, fz, nw, nr, e, rv);
        cmp("reld1024.rdata", rv, 32'hDEADBEEF);
        run_req(0, 1, 1, 32'd1032, 32'h77, rc, fz, nw, nr, e, rv);
        cmp("both.mem_write_pulses", 32'(nw), 32'd1);
        cmp("both.mem_read_pulses", 32'(nr), 32'd0);
        cmp("both.rdata_kept", rv, 32'hDEADBEEF);
        run_req(0, 1, 0, 32'd1032, 32'h0, rc, fz, nw, nr, e, rv);
        cmp("ld1032.rdata", rv, 32'h77);

        // Zero wait cycles, load issued in the IDLE cycle right after the store's ready.
        run_req(1, 0, 1, 32'd1028, 32'h5, rc, fz, nw, nr, e, rv);
        cmp("w0.st.freeze_cycles", 32'(fz), 32'd2);
        cmp("w0.st.ready_cycle", 32'(rc), 32'd2);
        run_req(1, 1, 0, 32'd1028, 32'h0, rc, fz, nw, nr, e, rv);
        cmp("w0.ld.freeze_cycles", 32'(fz), 32'd2);
        cmp("w0.ld.rdata", rv, 32'h5);

        // Reset during WAIT of a store must leave memory untouched.
        run_req(0, 0, 1, 32'd1036, 32'h11111111, rc, fz, nw, nr, e, rv);
        req_wr[0] = 1; req_addr[0] = 32'd1036; req_wdata[0] = 32'h22222222;
        nw = 0;
        @(negedge clk); nw += int'(mwr_w[0]);
        @(posedge clk); #1;
        @(negedge clk); nw += int'(mwr_w[0]);
        @(posedge clk); #1;
        rst = 1'b1; req_wr[0] = 0;
        @(negedge clk); nw += int'(mwr_w[0]);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); nw += int'(mwr_w[0]);
        cmp("rstwait.freeze", 32'(freeze_w[0]), 32'h0);
        cmp("rstwait.ready", 32'(ready_w[0]), 32'h0);
        cmp("rstwait.mem_write_pulses", 32'(nw), 32'd0);
        $display("txn w4 reset during WAIT of store 1036 -> freeze=%0b mem_write_pulses=%0d", freeze_w[0], nw);
        @(posedge clk); #1;
        run_req(0, 1, 0, 32'd1036, 32'h0, rc, fz, nw, nr, e, rv);
        cmp("ld1036.rdata_old", rv, 32'h11111111);
        cmp("ld1036.ready_cycle", 32'(rc), 32'd6);

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Sequencing controller between the MEM pipeline stage and the data memory (64 words, byte base address 1024, combinational read, write on rising clock edge). It latches one load/store request, inserts a fixed number of wait cycles to model slow memory, and strobes the memory for exactly one access cycle. It holds `freeze` high to stall the pipeline until the access completes. Out-of-range and misaligned addresses are rejected without touching memory.

## Interface
- `WAIT_CYCLES`, 4: wait cycles inserted before the access cycle; 0 is legal.
- `BASE_ADDR`, 1024: byte address of word 0.
- `DEPTH`, 64: memory depth in 32-bit words.

- `clk`  in  1  clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_read`  in  1  load request from MEM stage.
- `req_write`  in  1  store request from MEM stage.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data.
- `rdata`  out  32  registered load result.
- `ready`  out  1  one-cycle completion pulse.
- `err`  out  1  address fault flag, valid with `ready`.
- `freeze`  out  1  pipeline stall.
- `mem_read`  out  1  memory read enable.
- `mem_write`  out  1  memory write enable.
- `mem_address`  out  32  memory byte address.
- `mem_data`  out  32  memory write data.
- `mem_res`  in  32  memory read data (combinational).

## Operation
- States: IDLE, WAIT, ACCESS, DONE.
- **IDLE**
  - If `req_write` or `req_read` is high, latch op, `req_addr` and `req_wdata`.
  - If both are high, the write wins and the read is ignored.
  - Range check: fault if addr < BASE_ADDR, addr ≥ BASE_ADDR+4·DEPTH, or addr[1:0] ≠ 0.
  - On fault, go to DONE with fault flag set.
  - Otherwise go to WAIT, loading the counter with WAIT_CYCLES−1, or straight to ACCESS if WAIT_CYCLES = 0.
- **WAIT**: decrement the counter; go to ACCESS when the counter is 0.
- **ACCESS**: one cycle, then DONE.
  - Write: `mem_write` = 1.
  - Read: `mem_read` = 1, and `mem_res` is captured into `rdata` at the end of the cycle.
- **DONE**
  - `ready` = 1.
  - `err` = fault flag; on fault `rdata` is loaded with 0.
  - Always go to IDLE.
- `mem_address` and `mem_data` carry the latched values in WAIT and ACCESS, and are 0 in other states.
- `mem_read` and `mem_write` are high only in ACCESS.
- `freeze` = (IDLE ∧ (req_read ∨ req_write)) ∨ WAIT ∨ ACCESS. It is low in DONE so the pipeline advances on that edge.
- Requester rule: request inputs are held stable while `freeze` = 1. Changes during WAIT or ACCESS are ignored because values are latched.
- `rdata` holds its value until the next read or fault completion. A write does not change `rdata`.
- Counter width: max(1, clog2(WAIT_CYCLES+1)).

## Timing
- Reset values:
  - state IDLE, counter 0, fault flag 0.
  - `rdata` 0, `ready` 0, `err` 0, `freeze` 0.
  - all `mem_*` outputs 0.
- In-range access:
  - `freeze` is high for WAIT_CYCLES+2 cycles.
  - `ready` pulses in cycle WAIT_CYCLES+2, counting the request cycle as cycle 0.
- Faulted access: `freeze` high 1 cycle, `ready` and `err` in cycle 1, no memory strobe.
- Back-to-back: a request seen in the IDLE cycle right after DONE starts a new access. The minimum spacing between `ready` pulses is WAIT_CYCLES+3 cycles.
- Reset mid-operation: at the next edge the controller is in IDLE and all outputs are at reset values, with no `ready` pulse.
  - If `rst` is asserted during ACCESS with `mem_write` = 1, the write commits at that same edge.
- Idle with no request: all outputs hold at their reset values, except `rdata`, which keeps its last value.

## Structure
- Shared package `mem_pkg`, used by this block and the data memory, containing:
  - the state enum;
  - the `BASE_ADDR` and `DEPTH` constants;
  - an `addr_ok(addr)` function implementing the range and alignment check.
- No sub-module is required. The wait counter and FSM are in one module.
- The integration test instantiates this block directly in front of the existing data memory.

## Test plan
- Store 0xDEADBEEF to 1024, then load 1024, with WAIT_CYCLES = 4:
  - `freeze` is high for 6 cycles each time;
  - `mem_write` is high for exactly 1 cycle;
  - the load's `ready` coincides with `rdata` = 0xDEADBEEF and `err` = 0.
- Load from 1020, 1280 and 1026:
  - `ready` and `err` = 1 one cycle after the request, `rdata` = 0;
  - `mem_read` and `mem_write` stay 0 throughout.
- WAIT_CYCLES = 0:
  - store 0x5 to 1028, then load 1028 immediately after `ready`;
  - each access freezes for 2 cycles, and the load returns 0x5.
- `req_read` and `req_write` both high with address 1032 and data 0x77:
  - only `mem_write` pulses;
  - `rdata` is unchanged, and a subsequent load of 1032 returns 0x77.
- `rst` asserted during WAIT of a store to 1036:
  - next cycle the controller is IDLE with `freeze` = 0;
  - no `mem_write` occurs, and a later load of 1036 returns its old contents.
